// File: rtl/des_gate_interface.sv
// des_gate_interface: DES mesh gate; host job -> 5-flit request packet to router (credit flow), 3-flit result packet from router -> host with credit return
module des_gate_interface #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int SERIAL_WIDTH = 4,
  parameter int GATE_ID = 0,
  parameter int ROUTER_CREDITS = 2
) (
  input  logic clk,
  input  logic reset,
  output logic [CHANNEL_WIDTH-1:0] output_channel_dout,
  input  logic credit_in_din,
  input  logic [CHANNEL_WIDTH-1:0] input_channel_din,
  output logic credit_out_dout,
  input  logic job_valid_din,
  output logic job_ready_dout,
  input  logic [ADDR_WIDTH-1:0] dest_din,
  input  logic [SERIAL_WIDTH-1:0] serial_din,
  input  logic [2*CHANNEL_WIDTH-1:0] plaintext_din,
  input  logic [2*CHANNEL_WIDTH-1:0] key_din,
  output logic result_valid_dout,
  input  logic result_ready_din,
  output logic [2*CHANNEL_WIDTH-1:0] ciphertext_dout,
  output logic [SERIAL_WIDTH-1:0] result_serial_dout,
  output logic [ADDR_WIDTH-1:0] result_origin_dout,
  output logic result_witness_dout,
  output logic rx_overrun_dout
);
  localparam int CW = CHANNEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] GID = ADDR_WIDTH'(GATE_ID);
  localparam logic [2:0] MAX_CRED = 3'(ROUTER_CREDITS);
  typedef enum logic [2:0] {IDLE, HEAD, PT_HI, PT_LO, KEY_HI, KEY_LO} tx_state_t;
  typedef enum logic [1:0] {WAIT_HEAD, DATA_HI, DATA_LO, FULL} rx_state_t;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [2:0] credit_count;
  logic [2*CW-1:0] pt, key;
  logic [CW-1:0] head, dout_next;
  logic accept, release_slot, is_head;
  assign job_ready_dout = tx_state == IDLE && credit_count != 3'd0;
  assign accept = job_valid_din && job_ready_dout;
  assign is_head = input_channel_din[CW-1];
  assign result_valid_dout = rx_state == FULL;
  assign release_slot = result_valid_dout && result_ready_din;
  always_comb begin
    head = '0;
    head[CW-1] = 1'b1;
    head[SERIAL_WIDTH+3*ADDR_WIDTH-1:0] = {GID, dest_din, GID, serial_din};
  end
  always_comb begin
    tx_next = tx_state;
    dout_next = '0;
    case (tx_state)
      IDLE: begin
        tx_next = accept ? HEAD : IDLE;
        dout_next = accept ? head : '0;
      end
      HEAD: begin
        tx_next = PT_HI;
        dout_next = pt[2*CW-1:CW];
      end
      PT_HI: begin
        tx_next = PT_LO;
        dout_next = pt[CW-1:0];
      end
      PT_LO: begin
        tx_next = KEY_HI;
        dout_next = key[2*CW-1:CW];
      end
      KEY_HI: begin
        tx_next = KEY_LO;
        dout_next = key[CW-1:0];
      end
      default: tx_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      output_channel_dout <= '0;
      pt <= '0;
      key <= '0;
    end else begin
      tx_state <= tx_next;
      output_channel_dout <= dout_next;
      if (accept) begin
        pt <= plaintext_din;
        key <= key_din;
      end
    end
  end
  // simultaneous accept and returned credit cancel; returns beyond the router's slot count are ignored
  always_ff @(posedge clk) begin
    if (reset) credit_count <= MAX_CRED;
    else if (accept && !credit_in_din) credit_count <= credit_count - 3'd1;
    else if (!accept && credit_in_din && credit_count != MAX_CRED) credit_count <= credit_count + 3'd1;
  end
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      WAIT_HEAD: rx_next = is_head ? DATA_HI : WAIT_HEAD;
      DATA_HI:   rx_next = DATA_LO;
      DATA_LO:   rx_next = FULL;
      default:   rx_next = result_ready_din ? WAIT_HEAD : FULL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= WAIT_HEAD;
      credit_out_dout <= 1'b0;
      ciphertext_dout <= '0;
      result_serial_dout <= '0;
      result_origin_dout <= '0;
      result_witness_dout <= 1'b0;
      rx_overrun_dout <= 1'b0;
    end else begin
      rx_state <= rx_next;
      credit_out_dout <= release_slot;
      if (rx_state == WAIT_HEAD && is_head) begin
        result_serial_dout <= input_channel_din[SERIAL_WIDTH-1:0];
        result_origin_dout <= input_channel_din[SERIAL_WIDTH+ADDR_WIDTH-1:SERIAL_WIDTH];
        result_witness_dout <= input_channel_din[CW-2];
      end
      if (rx_state == DATA_HI) ciphertext_dout[2*CW-1:CW] <= input_channel_din;
      if (rx_state == DATA_LO) ciphertext_dout[CW-1:0] <= input_channel_din;
      // a header while the slot is full means the router ignored our credits; drop it and flag
      if (rx_state == FULL && is_head) rx_overrun_dout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_des_gate_interface.sv
// tb_des_gate_interface: directed stimulus, per-cycle comparison against a queue-based packet model plus literal spot checks
module tb_des_gate_interface;
  localparam int RC = 2;
  localparam int GID = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] out_dout;
  logic credit_in = 1'b0;
  logic [31:0] in_din = '0;
  logic credit_out;
  logic job_valid = 1'b0;
  logic job_ready;
  logic [3:0] dest = '0;
  logic [3:0] serial = '0;
  logic [63:0] pt = '0;
  logic [63:0] key = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [63:0] ct;
  logic [3:0] res_serial;
  logic [3:0] res_origin;
  logic res_wit;
  logic overrun;
  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  bit [31:0] m_q[$];
  bit [31:0] m_asm[$];
  bit [31:0] m_cur;
  bit m_cur_v, m_acc, m_held, m_cout, m_ovr, m_wit;
  int m_cred;
  bit [63:0] m_ct;
  bit [3:0] m_ser, m_org;

  des_gate_interface #(.CHANNEL_WIDTH(32), .ADDR_WIDTH(4), .SERIAL_WIDTH(4), .GATE_ID(GID), .ROUTER_CREDITS(RC)) dut (
    .clk(clk), .reset(reset), .output_channel_dout(out_dout), .credit_in_din(credit_in),
    .input_channel_din(in_din), .credit_out_dout(credit_out), .job_valid_din(job_valid),
    .job_ready_dout(job_ready), .dest_din(dest), .serial_din(serial), .plaintext_din(pt),
    .key_din(key), .result_valid_dout(res_valid), .result_ready_din(res_ready),
    .ciphertext_dout(ct), .result_serial_dout(res_serial), .result_origin_dout(res_origin),
    .result_witness_dout(res_wit), .rx_overrun_dout(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_q.size() == 0 && !m_cur_v && m_cred != 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_asm.delete();
      m_cur = '0;
      m_cur_v = 1'b0;
      m_cred = RC;
      m_held = 1'b0;
      m_cout = 1'b0;
      m_ovr = 1'b0;
      m_ct = '0;
      m_ser = '0;
      m_org = '0;
      m_wit = 1'b0;
      run = 1'b1;
    end else begin
      m_acc = job_valid && m_ready();
      if (m_acc) begin
        m_q.push_back({2'b10, 14'b0, 4'(GID), dest, 4'(GID), serial});
        m_q.push_back(pt[63:32]);
        m_q.push_back(pt[31:0]);
        m_q.push_back(key[63:32]);
        m_q.push_back(key[31:0]);
      end
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_cur_v = 1'b1;
      end else begin
        m_cur = '0;
        m_cur_v = 1'b0;
      end
      m_cred = m_cred - int'(m_acc) + int'(credit_in);
      if (m_cred > RC) m_cred = RC;
      m_cout = 1'b0;
      if (m_held) begin
        if (in_din[31]) m_ovr = 1'b1;
        if (res_ready) begin
          m_held = 1'b0;
          m_cout = 1'b1;
        end
      end else if (m_asm.size() > 0 || in_din[31]) begin
        m_asm.push_back(in_din);
        if (m_asm.size() == 3) begin
          m_held = 1'b1;
          m_ser = m_asm[0][3:0];
          m_org = m_asm[0][7:4];
          m_wit = m_asm[0][30];
          m_ct = {m_asm[1], m_asm[2]};
          m_asm.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model dout", 64'(out_dout), 64'(m_cur));
      chk("model job_ready", 64'(job_ready), 64'(m_ready()));
      chk("model result_valid", 64'(res_valid), 64'(m_held));
      chk("model credit_out", 64'(credit_out), 64'(m_cout));
      chk("model overrun", 64'(overrun), 64'(m_ovr));
      if (m_held) begin
        chk("model ciphertext", ct, m_ct);
        chk("model serial", 64'(res_serial), 64'(m_ser));
        chk("model origin", 64'(res_origin), 64'(m_org));
        chk("model witness", 64'(res_wit), 64'(m_wit));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("reset dout", 64'(out_dout), 64'h0);
    chk("reset job_ready", 64'(job_ready), 64'h1);
    chk("reset result_valid", 64'(res_valid), 64'h0);
    chk("reset credit_out", 64'(credit_out), 64'h0);
    chk("reset overrun", 64'(overrun), 64'h0);
    chk("reset ciphertext", ct, 64'h0);
    reset = 1'b0;
    dest = 4'h3;
    serial = 4'hA;
    pt = 64'h0123456789ABCDEF;
    key = 64'h133457799BBCDFF1;
    tick();
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("tx header", 64'(out_dout), 64'h8000232A);
    tick();
    chk("tx pt_hi", 64'(out_dout), 64'h01234567);
    tick();
    chk("tx pt_lo", 64'(out_dout), 64'h89ABCDEF);
    tick();
    chk("tx key_hi", 64'(out_dout), 64'h13345779);
    tick();
    chk("tx key_lo", 64'(out_dout), 64'h9BBCDFF1);
    tick();
    chk("tx idle dout", 64'(out_dout), 64'h0);
    chk("tx ready one credit", 64'(job_ready), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    job_valid = 1'b1;
    tick(6);
    chk("second job ready", 64'(job_ready), 64'h1);
    tick();
    chk("second header", 64'(out_dout), 64'h8000232A);
    tick(5);
    chk("exhausted ready", 64'(job_ready), 64'h0);
    tick(6);
    chk("still exhausted", 64'(job_ready), 64'h0);
    chk("no third packet", 64'(out_dout), 64'h0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("ready after credit", 64'(job_ready), 64'h1);
    tick();
    job_valid = 1'b0;
    chk("third header", 64'(out_dout), 64'h8000232A);
    tick(5);
    credit_in = 1'b1;
    tick();
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    credit_in = 1'b0;
    tick(5);
    chk("count kept at one", 64'(job_ready), 64'h1);
    credit_in = 1'b1;
    tick(2);
    credit_in = 1'b0;
    job_valid = 1'b1;
    tick(12);
    chk("saturated at two", 64'(job_ready), 64'h0);
    job_valid = 1'b0;
    tick(6);
    in_din = 32'hC0003A27;
    tick();
    in_din = 32'h85E81354;
    tick();
    in_din = 32'h0F0AB405;
    tick();
    in_din = 32'h0;
    chk("rx valid", 64'(res_valid), 64'h1);
    chk("rx ciphertext", ct, 64'h85E813540F0AB405);
    chk("rx serial", 64'(res_serial), 64'h7);
    chk("rx origin", 64'(res_origin), 64'h2);
    chk("rx witness", 64'(res_wit), 64'h1);
    tick(3);
    in_din = 32'h80001234;
    tick();
    in_din = 32'h11111111;
    tick();
    in_din = 32'h0;
    chk("overrun set", 64'(overrun), 64'h1);
    chk("held after overrun", ct, 64'h85E813540F0AB405);
    chk("held serial after overrun", 64'(res_serial), 64'h7);
    chk("no credit on overrun", 64'(credit_out), 64'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("credit_out pulse", 64'(credit_out), 64'h1);
    chk("released", 64'(res_valid), 64'h0);
    tick();
    chk("credit_out single", 64'(credit_out), 64'h0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    job_valid = 1'b1;
    pt = 64'hFEDCBA9876543210;
    tick();
    job_valid = 1'b0;
    tick();
    in_din = 32'hC0001155;
    tick();
    in_din = 32'hAAAA0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_din = 32'h11112222;
    chk("abort dout", 64'(out_dout), 64'h0);
    chk("abort result_valid", 64'(res_valid), 64'h0);
    chk("abort ready", 64'(job_ready), 64'h1);
    chk("abort overrun cleared", 64'(overrun), 64'h0);
    tick(2);
    in_din = 32'h0;
    chk("no flits after abort", 64'(out_dout), 64'h0);
    tick(3);
    in_din = 32'h80000045;
    tick();
    in_din = 32'h00000001;
    tick();
    in_din = 32'h00000002;
    tick();
    in_din = 32'h0;
    chk("rx after abort", ct, 64'h0000000100000002);
    chk("rx serial after abort", 64'(res_serial), 64'h5);
    job_valid = 1'b1;
    tick(7);
    job_valid = 1'b0;
    tick(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
